multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum memory wait cycles per access before timeout fault.
REQ-002 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 mem_ready  input  1  memory completes the current access this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA  output  1 each  datapath strobes and selects, classic multicycle meaning.
REQ-007 ALUSrcB  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-008 ALUOp  output  2  00=add, 01=sub, 10=funct-driven, to ALUControl.
REQ-009 PCSource  output  2  00=ALU result, 01=ALUOut register, 10=jump target.
REQ-010 fault  output  1  sticky error flag: illegal opcode or memory timeout.
REQ-011 state_dbg  output  4  current state encoding.

Function
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BEQ, ADDIEX, ADDIWB, JUMP, FAULT.
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite asserted only in the cycle mem_ready=1, then -> DECODE; else stay.
REQ-014 DECODE (one cycle): ALUSrcA=0, ALUSrcB=11, ALUOp=00; next by opcode: 0x23/0x2B->MEMADR, 0x00->REXEC, 0x04->BEQ, 0x08->ADDIEX, 0x02->JUMP, other->FAULT.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->MEMRD if lw, ->MEMWR if sw.
REQ-016 MEMRD: MemRead=1, IorD=1; on mem_ready ->MEMWB. MEMWR: MemWrite=1, IorD=1; on mem_ready ->FETCH.
REQ-017 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; ->FETCH.
REQ-018 REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 ->RWB; RWB: RegWrite=1, RegDst=1, MemtoReg=0 ->FETCH.
REQ-019 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 ->FETCH.
REQ-020 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 ->ADDIWB; ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 ->FETCH.
REQ-021 JUMP: PCWrite=1, PCSource=10 ->FETCH.
REQ-022 Outputs are Moore (state-decoded) except IRWrite/PCWrite in FETCH, which are gated by mem_ready; every strobe not listed for a state is 0.
REQ-023 Latency: R-type/addi/sw 4 cycles, lw 5, beq/j 3, with mem_ready=1 in every access cycle; each wait cycle adds one.
REQ-024 A wait counter (width ceil(log2(WAIT_MAX+1))) clears on entering FETCH/MEMRD/MEMWR and increments each cycle mem_ready=0 there; reaching WAIT_MAX with mem_ready=0 -> FAULT.
REQ-025 mem_ready in the same cycle the counter reaches WAIT_MAX completes the access normally (ready wins).
REQ-026 mem_ready is ignored in all non-memory states.
REQ-027 FAULT: all strobes 0, fault=1, remain until RESET.
REQ-028 opcode is sampled only in DECODE; changes elsewhere have no effect.

Reset
REQ-029 RESET=1 at posedge CLK -> state FETCH, wait counter 0, fault 0, regardless of current state (including mid-access or FAULT).
REQ-030 While RESET is asserted all write strobes (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) SHALL be 0 in the following cycle; first fetch begins the cycle after RESET deasserts.

Structure
REQ-031 State encoding, opcode constants (R=0x00, LW=0x23, SW=0x2B, BEQ=0x04, ADDI=0x08, J=0x02) and ALUOp/ALUSrcB/PCSource codes belong in a shared package mips_ctrl_pkg.
REQ-032 One sub-module, mc_wait_timer, implements the wait counter and timeout flag; the output decode stays in the top block.

Verification
REQ-033 add (opcode 0x00), mem_ready always 1 -> states FETCH,DECODE,REXEC,RWB; RegWrite=1, RegDst=1 in cycle 4 only.
REQ-034 lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, total 8 cycles, single RegWrite pulse with MemtoReg=1.
REQ-035 beq then j back-to-back -> PCWriteCond=1/PCSource=01 in BEQ, PCWrite=1/PCSource=10 in JUMP, each 3 cycles.
REQ-036 opcode 0x3F in DECODE -> FAULT next cycle, fault=1, all strobes 0 for 20 cycles; RESET -> FETCH, fault=0.
REQ-037 mem_ready held 0 in FETCH with WAIT_MAX=15 -> FAULT after 15 wait cycles; variant with mem_ready=1 on cycle 15 -> DECODE, no fault.
REQ-038 RESET asserted in MEMWR mid-wait -> next state FETCH, MemWrite=0, counter 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit:
// state encoding, opcode values and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States in which the control unit waits on memory.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts not-ready cycles of the current access and
// flags a timeout once WAIT_MAX wait cycles have elapsed and memory is
// still not ready.
module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam int unsigned CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(WAIT_MAX);

    logic [CW-1:0] count;

    // Cleared outside memory states and on access completion, so every
    // access starts counting from zero; saturates at WAIT_MAX.
    always_ff @(posedge CLK) begin
        if (RESET || !active || mem_ready) begin
            count <= '0;
        end else if (count != CMAX) begin
            count <= count + CW'(1);
        end
    end

    // Ready in the cycle the count reaches WAIT_MAX still completes the access.
    assign timeout = active && !mem_ready && (count == CMAX);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute for
// R-type, lw, sw, beq, addi and j, with memory wait handling and a
// sticky fault state for illegal opcodes and memory timeouts.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       fault,
    output logic [3:0] state_dbg
);

    state_t state;
    logic   is_sw;
    logic   timeout;

    mc_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .CLK       (CLK),
        .RESET     (RESET),
        .active    (is_mem_state(state)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    // State sequencing; lw/sw choice is captured in DECODE so opcode is
    // ignored in every later state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_FETCH;
            is_sw <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (timeout)        state <= S_FAULT;
                    else if (mem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    is_sw <= (opcode == OP_SW);
                    case (opcode)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_REXEC;
                        OP_BEQ:       state <= S_BEQ;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JUMP;
                        default:      state <= S_FAULT;
                    endcase
                end
                S_MEMADR: state <= is_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (timeout)        state <= S_FAULT;
                    else if (mem_ready) state <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (timeout)        state <= S_FAULT;
                    else if (mem_ready) state <= S_FETCH;
                end
                S_MEMWB:  state <= S_FETCH;
                S_REXEC:  state <= S_RWB;
                S_RWB:    state <= S_FETCH;
                S_BEQ:    state <= S_FETCH;
                S_ADDIEX: state <= S_ADDIWB;
                S_ADDIWB: state <= S_FETCH;
                S_JUMP:   state <= S_FETCH;
                S_FAULT:  state <= S_FAULT;
                default:  state <= S_FAULT;
            endcase
        end
    end

    // Moore output decode; IRWrite/PCWrite in FETCH follow mem_ready, and
    // write strobes are forced off while RESET is held.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        fault       = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = SRCB_IMMSH2;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_FAULT:  fault = 1'b1;
            default:  fault = 1'b1;
        endcase
        if (RESET) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: the stimulus side
// expands each instruction into its phase sequence and queues the expected
// outputs of every cycle; a monitor compares them on the falling edge.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    localparam int unsigned WM = 15;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegDst, RegWrite, ALUSrcA, fault;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_dbg;

    multicycle_control #(
        .WAIT_MAX(WM)
    ) dut (
        .CLK(CLK), .RESET(RESET), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .fault(fault), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pcw, pcwc, iord, mr, mw, m2r, irw, rd, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic       flt;
        logic [3:0] st;
    } vec_t;

    typedef struct {
        vec_t v;
        vec_t m;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    failures = 0;

    // Expected outputs for one cycle spent in a given phase, from the
    // per-state output table of the control unit.
    function automatic vec_t exp_out(state_t s, bit rdy);
        vec_t v = '0;
        v.st = 4'(s);
        case (s)
            S_FETCH:  begin v.mr = 1; v.asb = 2'b01; v.irw = rdy; v.pcw = rdy; end
            S_DECODE: v.asb = 2'b11;
            S_MEMADR: begin v.asa = 1; v.asb = 2'b10; end
            S_MEMRD:  begin v.mr = 1; v.iord = 1; end
            S_MEMWR:  begin v.mw = 1; v.iord = 1; end
            S_MEMWB:  begin v.rw = 1; v.m2r = 1; end
            S_REXEC:  begin v.asa = 1; v.aop = 2'b10; end
            S_RWB:    begin v.rw = 1; v.rd = 1; end
            S_BEQ:    begin v.asa = 1; v.aop = 2'b01; v.pcwc = 1; v.pcs = 2'b01; end
            S_ADDIEX: begin v.asa = 1; v.asb = 2'b10; end
            S_ADDIWB: v.rw = 1;
            S_JUMP:   begin v.pcw = 1; v.pcs = 2'b10; end
            S_FAULT:  v.flt = 1;
            default:  v = '0;
        endcase
        return v;
    endfunction

    function automatic vec_t write_mask();
        vec_t m = '0;
        m.pcw = 1; m.pcwc = 1; m.irw = 1; m.mw = 1; m.rw = 1;
        return m;
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic bit rbit();
        return 1'($urandom);
    endfunction

    // One clock cycle of stimulus plus its queued expectation. During reset
    // cycles only the write strobes are defined (all zero).
    task automatic step(input state_t s, input logic [5:0] op, input bit rdy, input bit rst);
        item_t it;
        opcode    = op;
        mem_ready = rdy;
        RESET     = rst;
        if (rst) begin
            it.v = '0;
            it.m = write_mask();
        end else begin
            it.v = exp_out(s, rdy);
            it.m = '1;
        end
        sb.push_back(it);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(S_FETCH, rop(), rbit(), 1'b1);
    endtask

    // A memory access: up to WM not-ready cycles are tolerated; one more
    // not-ready cycle is a timeout.
    task automatic mem_phase(input state_t s, input int waits, output bit timed_out);
        int n;
        n = (waits > int'(WM)) ? int'(WM) + 1 : waits;
        repeat (n) step(s, rop(), 1'b0, 1'b0);
        timed_out = (waits > int'(WM));
        if (!timed_out) step(s, rop(), 1'b1, 1'b0);
    endtask

    task automatic fault_phase(input int n);
        repeat (n) step(S_FAULT, rop(), rbit(), 1'b0);
        do_reset(1);
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        bit to;
        mem_phase(S_FETCH, wf, to);
        if (to) begin
            fault_phase(5);
            return;
        end
        step(S_DECODE, op, rbit(), 1'b0);
        case (op)
            6'h23: begin
                step(S_MEMADR, rop(), rbit(), 1'b0);
                mem_phase(S_MEMRD, wm, to);
                if (to) begin
                    fault_phase(5);
                    return;
                end
                step(S_MEMWB, rop(), rbit(), 1'b0);
            end
            6'h2B: begin
                step(S_MEMADR, rop(), rbit(), 1'b0);
                mem_phase(S_MEMWR, wm, to);
                if (to) fault_phase(5);
            end
            6'h00: begin
                step(S_REXEC, rop(), rbit(), 1'b0);
                step(S_RWB, rop(), rbit(), 1'b0);
            end
            6'h04: step(S_BEQ, rop(), rbit(), 1'b0);
            6'h08: begin
                step(S_ADDIEX, rop(), rbit(), 1'b0);
                step(S_ADDIWB, rop(), rbit(), 1'b0);
            end
            6'h02: step(S_JUMP, rop(), rbit(), 1'b0);
            default: fault_phase(20);
        endcase
    endtask

    // Monitor: every cycle the DUT presents a full output vector, compared
    // against the oldest queued expectation.
    vec_t  mon_act;
    item_t mon_it;
    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            mon_it = sb.pop_front();
            mon_act = '0;
            mon_act.pcw = PCWrite;   mon_act.pcwc = PCWriteCond; mon_act.iord = IorD;
            mon_act.mr  = MemRead;   mon_act.mw   = MemWrite;    mon_act.m2r  = MemtoReg;
            mon_act.irw = IRWrite;   mon_act.rd   = RegDst;      mon_act.rw   = RegWrite;
            mon_act.asa = ALUSrcA;   mon_act.asb  = ALUSrcB;     mon_act.aop  = ALUOp;
            mon_act.pcs = PCSource;  mon_act.flt  = fault;       mon_act.st   = state_dbg;
            checks++;
            if ((mon_act & mon_it.m) !== (mon_it.v & mon_it.m)) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h mask=%h (state actual=%0d required=%0d)",
                         $time, mon_act, mon_it.v, mon_it.m, mon_act.st, mon_it.v.st);
            end
        end
    end

    logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

    initial begin
        bit to;
        @(posedge CLK);
        #1;
        do_reset(2);

        // add, no waits
        run_instr(6'h00, 0, 0);
        // lw with three MEMRD wait cycles
        run_instr(6'h23, 0, 3);
        // beq then j back-to-back
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);
        // addi and sw, no waits
        run_instr(6'h08, 0, 0);
        run_instr(6'h2B, 0, 0);
        // illegal opcode: 20 fault cycles then reset
        run_instr(6'h3F, 0, 0);
        // fetch timeout, then ready exactly at the limit
        run_instr(6'h00, WM + 1, 0);
        run_instr(6'h00, WM, 0);
        // memory-read and memory-write timeouts, and write ready at the limit
        run_instr(6'h23, 0, WM + 1);
        run_instr(6'h2B, 1, WM);

        // reset in the middle of a waiting store, then a full-length fetch
        // wait that only survives if the counter was cleared
        mem_phase(S_FETCH, 0, to);
        step(S_DECODE, 6'h2B, 1'b0, 1'b0);
        step(S_MEMADR, rop(), rbit(), 1'b0);
        step(S_MEMWR, rop(), 1'b0, 1'b0);
        step(S_MEMWR, rop(), 1'b0, 1'b0);
        do_reset(1);
        run_instr(6'h00, WM, 0);

        // randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            logic [5:0] op;
            int wf, wm, r;
            op = (($urandom_range(0, 11)) == 0) ? rop() : ops[$urandom_range(0, 5)];
            r  = int'($urandom_range(0, 39));
            wf = (r == 0) ? int'(WM) + 1 : (r == 1) ? int'(WM) : int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 39));
            wm = (r == 0) ? int'(WM) + 1 : (r == 1) ? int'(WM) : int'($urandom_range(0, 3));
            run_instr(op, wf, wm);
            if ($urandom_range(0, 29) == 0) do_reset(1);
        end

        @(negedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
